// File: rtl/barrel_shifter_seq.sv
// Sequential barrel shifter: one log2 stage per cycle, rotate/logical/arithmetic,
// valid/ready handshake on both sides.

module bs_stage #(
   parameter int WIDTH = 10,
   parameter int SH    = 1
) (
   input  logic [WIDTH-1:0] d,
   input  logic             dir,
   input  logic [1:0]       mode,
   output logic [WIDTH-1:0] q
);
   // Rotation by SH is rotation by SH mod WIDTH; plain shifts >= WIDTH saturate naturally.
   localparam int R = SH % WIDTH;

   logic [WIDTH-1:0] rot, lsh, ash;

   always_comb begin
      rot = dir ? ((d << R) | (d >> (WIDTH - R))) : ((d >> R) | (d << (WIDTH - R)));
      lsh = dir ? (d << SH) : (d >> SH);
      ash = dir ? (d << SH) : WIDTH'($signed(d) >>> SH);
      case (mode)
         2'b01:   q = lsh;
         2'b10:   q = ash;
         default: q = rot;
      endcase
   end
endmodule

module barrel_shifter_seq #(
   parameter int WIDTH = 10,
   parameter int SHW   = $clog2(WIDTH)
) (
   input  logic             CLK,
   input  logic             RSTn,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   input  logic [SHW-1:0]   shift_amt,
   input  logic             direction,
   input  logic [1:0]       mode,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data,
   output logic             busy
);
   typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

   state_t               state, state_nxt;
   logic [WIDTH-1:0]     work, work_nxt;
   logic [SHW-1:0]       amt, eff;
   logic [SHW-1:0]       stg;          // one-hot stage pointer, bit k = stage k
   logic                 dir_q;
   logic [1:0]           mode_q;
   logic [31:0]          amt_ext;
   logic [SHW-1:0][WIDTH-1:0] stg_q;

   genvar g;
   generate
      for (g = 0; g < SHW; g++) begin : g_stage
         bs_stage #(.WIDTH(WIDTH), .SH(2 ** g)) u_stage (
            .d    (work),
            .dir  (dir_q),
            .mode (mode_q),
            .q    (stg_q[g])
         );
      end
   endgenerate

   // Reserved mode 11 rotates, so it also gets the modulo reduction.
   always_comb begin
      amt_ext = 32'(shift_amt);
      eff     = shift_amt;
      if ((mode[0] == mode[1]) && (amt_ext >= WIDTH))
         eff = SHW'(amt_ext - WIDTH);
   end

   always_comb begin
      work_nxt = work;
      for (int k = 0; k < SHW; k++)
         if (stg[k] && amt[k]) work_nxt = stg_q[k];
   end

   always_comb begin
      state_nxt = state;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      busy      = 1'b0;
      case (state)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid) state_nxt = SHIFT;
         end
         SHIFT: begin
            busy = 1'b1;
            if (stg[SHW-1]) state_nxt = DONE;
         end
         DONE: begin
            busy      = 1'b1;
            out_valid = 1'b1;
            if (out_ready) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (!RSTn) state <= IDLE;
      else       state <= state_nxt;
   end

   always_ff @(posedge CLK) begin
      if (!RSTn) begin
         work     <= '0;
         amt      <= '0;
         stg      <= '0;
         dir_q    <= 1'b0;
         mode_q   <= 2'b00;
         out_data <= '0;
      end else begin
         case (state)
            IDLE: if (in_valid) begin
               work   <= in_data;
               amt    <= eff;
               dir_q  <= direction;
               mode_q <= mode;
               stg    <= SHW'(1);
            end
            SHIFT: begin
               work <= work_nxt;
               stg  <= stg << 1;
               if (stg[SHW-1]) out_data <= work_nxt;
            end
            default: ;
         endcase
      end
   end
endmodule

// File: tb/tb_barrel_shifter_seq.sv
// Scoreboard bench for barrel_shifter_seq (WIDTH=10, SHW=4): directed vectors,
// random ops with backpressure, mid-shift reset.

module tb_barrel_shifter_seq;
   localparam int W = 10;
   localparam int S = 4;

   logic         CLK = 1'b0;
   logic         RSTn, in_valid, in_ready, direction, out_valid, out_ready, busy;
   logic [W-1:0] in_data, out_data;
   logic [S-1:0] shift_amt;
   logic [1:0]   mode;

   int           vectors = 0;
   int           errs = 0;
   logic [W-1:0] sb[$];
   logic [W-1:0] last = '0;

   always #5 CLK = ~CLK;

   barrel_shifter_seq #(.WIDTH(W), .SHW(S)) dut (
      .CLK(CLK), .RSTn(RSTn), .in_valid(in_valid), .in_ready(in_ready),
      .in_data(in_data), .shift_amt(shift_amt), .direction(direction), .mode(mode),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .busy(busy)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      if (obs !== exp) begin
         errs++;
         $display("FAIL %s: got %0h want %0h", tag, obs, exp);
      end
   endtask

   // Bit-at-a-time reference, independent of the staged structure.
   function automatic logic [W-1:0] model(input logic [W-1:0] d, input int a,
                                          input logic dir, input logic [1:0] m);
      logic [W-1:0] r = d;
      if (m == 2'b01 || (m == 2'b10 && dir)) begin
         repeat (a) r = dir ? (r << 1) : (r >> 1);
      end else if (m == 2'b10) begin
         repeat (a) r = {r[W-1], r[W-1:1]};
      end else begin
         repeat (a % W) r = dir ? {r[W-2:0], r[W-1]} : {r[0], r[W-1:1]};
      end
      return r;
   endfunction

   task automatic scramble();
      in_data   = W'($urandom);
      shift_amt = S'($urandom);
      direction = 1'($urandom);
      mode      = 2'($urandom);
   endtask

   task automatic do_op(input logic [W-1:0] d, input logic [S-1:0] a, input logic dir,
                        input logic [1:0] m, input logic [W-1:0] exp, input int bp);
      logic [W-1:0] e, held;
      int n;
      @(negedge CLK);
      chk("idle_ready", in_ready, 1);
      in_valid = 1'b1; in_data = d; shift_amt = a; direction = dir; mode = m;
      sb.push_back(exp);
      @(posedge CLK); #1;
      in_valid = 1'b0;
      scramble();
      chk("busy_after_accept", busy, 1);
      for (int i = 1; i <= S; i++) begin
         if (i < S) begin
            chk("no_early_valid", out_valid, 0);
            chk("out_hold_shift", out_data, last);
            chk("not_ready_shift", in_ready, 0);
         end
         @(posedge CLK); #1;
      end
      chk("valid_at_latency", out_valid, 1);
      n = 0;
      while (!out_valid && n < 20) begin
         @(posedge CLK); #1; n++;
      end
      if (!out_valid) begin
         chk("valid_timeout", 0, 1);
         void'(sb.pop_front());
         return;
      end
      e = sb.pop_front();
      chk("result", out_data, e);
      held = out_data;
      for (int j = 0; j < bp; j++) begin
         @(posedge CLK); #1;
         chk("bp_stable", out_data, held);
         chk("bp_valid", out_valid, 1);
         chk("bp_not_ready", in_ready, 0);
      end
      out_ready = 1'b1;
      @(posedge CLK); #1;
      out_ready = 1'b0;
      chk("ready_after_consume", in_ready, 1);
      chk("valid_drop", out_valid, 0);
      chk("idle_not_busy", busy, 0);
      chk("out_hold_idle", out_data, e);
      last = e;
   endtask

   initial begin
      RSTn = 1'b0; in_valid = 1'b1; out_ready = 1'b0;
      in_data = 10'h155; shift_amt = 4'd3; direction = 1'b1; mode = 2'b00;
      repeat (3) @(posedge CLK);
      #1;
      chk("rst_in_ready", in_ready, 1);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_busy", busy, 0);
      chk("rst_out_data", out_data, 0);
      in_valid = 1'b0; RSTn = 1'b1;

      do_op(10'h201, 4'd1,  1'b1, 2'b00, 10'h003, 0);
      do_op(10'h001, 4'd3,  1'b0, 2'b00, 10'h080, 0);
      do_op(10'h001, 4'd12, 1'b1, 2'b00, 10'h004, 0);
      do_op(10'h3FF, 4'd4,  1'b1, 2'b01, 10'h3F0, 0);
      do_op(10'h3FF, 4'd12, 1'b0, 2'b01, 10'h000, 0);
      do_op(10'h200, 4'd2,  1'b0, 2'b10, 10'h380, 0);
      do_op(10'h200, 4'd15, 1'b0, 2'b10, 10'h3FF, 5);
      for (int m = 0; m < 4; m++)
         do_op(10'h2A5, 4'd0, 1'(m), 2'(m), 10'h2A5, 0);

      // Reset while the stage pointer sits at stage 2.
      @(negedge CLK);
      in_valid = 1'b1; in_data = 10'h0F0; shift_amt = 4'd7; direction = 1'b1; mode = 2'b00;
      sb.push_back(model(10'h0F0, 7, 1'b1, 2'b00));
      @(posedge CLK); #1;
      scramble();
      repeat (2) begin @(posedge CLK); #1; end
      RSTn = 1'b0;
      @(posedge CLK); #1;
      RSTn = 1'b1; in_valid = 1'b0;
      sb.delete();
      chk("midrst_in_ready", in_ready, 1);
      chk("midrst_busy", busy, 0);
      chk("midrst_out_valid", out_valid, 0);
      chk("midrst_out_data", out_data, 0);
      last = '0;
      repeat (6) begin
         @(posedge CLK); #1;
         chk("midrst_no_pulse", out_valid, 0);
      end
      do_op(10'h0F0, 4'd7, 1'b1, 2'b00, model(10'h0F0, 7, 1'b1, 2'b00), 1);

      for (int t = 0; t < 20; t++) begin
         logic [W-1:0] d;
         logic [S-1:0] a;
         logic         dr;
         logic [1:0]   m;
         d = W'($urandom); a = S'($urandom); dr = 1'($urandom); m = 2'($urandom);
         do_op(d, a, dr, m, model(d, int'(a), dr, m), int'($urandom_range(0, 2)));
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
      $finish;
   end
endmodule

// File: doc/barrel_shifter_seq.md
BARREL_SHIFTER_SEQ -- requirements
Module: barrel_shifter_seq

Interface
REQ-001 Parameter WIDTH, default 10, data width in bits; SHALL be at least 2.
REQ-002 Parameter SHW, default $clog2(WIDTH), shift-amount width; SHALL be at least 1.
REQ-003 CLK  input  1  sole clock; all state SHALL update on its rising edge.
REQ-004 RSTn  input  1  reset; synchronous, active-low.
REQ-005 in_valid  input  1  request valid.
REQ-006 in_ready  output  1  block can accept a request.
REQ-007 in_data  input  WIDTH  operand.
REQ-008 shift_amt  input  SHW  shift distance.
REQ-009 direction  input  1  1 = left (toward MSB), 0 = right.
REQ-010 mode  input  2  00 rotate, 01 logical, 10 arithmetic, 11 reserved (SHALL behave as 00).
REQ-011 out_valid  output  1  result valid.
REQ-012 out_ready  input  1  consumer accepts result.
REQ-013 out_data  output  WIDTH  result.
REQ-014 busy  output  1  high in SHIFT or DONE.

Function
REQ-015 FSM SHALL have exactly three states: IDLE, SHIFT, DONE.
REQ-016 in_ready SHALL be 1 only in IDLE; out_valid SHALL be 1 only in DONE.
REQ-017 Accept: at an edge with state IDLE and in_valid=1, the block SHALL capture in_data, direction, and mode, plus the effective amount; the state SHALL go to SHIFT with stage counter = 0.
REQ-018 Effective amount: rotate SHALL use shift_amt-WIDTH when shift_amt>=WIDTH, else shift_amt (one subtraction suffices because 2^SHW < 2*WIDTH); logical/arithmetic SHALL use shift_amt unchanged.
REQ-019 SHIFT: each cycle SHALL process stage k (k = 0..SHW-1); if bit k of the effective amount is 1, the working register SHALL be shifted by 2^k in the captured direction and mode, else held; then k increments.
REQ-020 Fill rules: logical SHALL shift in zeros; arithmetic right SHALL shift in the captured MSB; arithmetic left SHALL equal logical left; rotate SHALL wrap bits end-around.
REQ-021 Stage shifts by 2^k >= WIDTH SHALL yield all zeros for logical, all copies of the MSB for arithmetic right, and the correct end-around result for rotate.
REQ-022 After stage SHW-1, the state SHALL go to DONE; out_valid SHALL rise exactly SHW edges after the accepting edge, independent of amount (amount 0 included).
REQ-023 DONE: out_data SHALL be held stable while out_ready=0; at the edge with out_ready=1, the state SHALL go to IDLE.
REQ-024 No new request SHALL be accepted in the same cycle that a result is consumed (in_ready rises the cycle after).
REQ-025 in_data, shift_amt, direction, and mode changes after acceptance SHALL NOT affect the in-flight result.
REQ-026 out_data SHALL retain the last result in IDLE and SHIFT until the next DONE.

Reset
REQ-027 At an edge with RSTn=0, the state SHALL go to IDLE, the stage counter to 0, and out_data, working register, and captured fields to 0; out_valid=0, busy=0, in_ready=1 from the following cycle.
REQ-028 Reset SHALL take priority over all other events, including mid-SHIFT and DONE with out_ready=1; any in-flight result SHALL be discarded and no out_valid pulse SHALL follow.
REQ-029 in_valid=1 in the same cycle as RSTn=0 SHALL NOT be accepted.

Verification (WIDTH=10, SHW=4)
REQ-030 Rotate left 1 of 10'h201 -> out_data=10'h003, with out_valid 4 cycles after accept.
REQ-031 Rotate right 3 of 10'h001 -> 10'h080; rotate left 12 of 10'h001 -> 10'h004 (amount reduced to 2).
REQ-032 Logical left 4 of 10'h3FF -> 10'h3F0; logical right 12 of 10'h3FF -> 10'h000; arithmetic right 2 of 10'h200 -> 10'h380; arithmetic right 15 of 10'h200 -> 10'h3FF.
REQ-033 Backpressure: hold out_ready=0 for 5 cycles in DONE -> out_data stable, in_ready=0 throughout; in_ready=1 one cycle after out_ready=1.
REQ-034 Assert RSTn=0 for one cycle during SHIFT stage 2 -> IDLE next cycle, out_data=0, no out_valid; the next request completes correctly.
REQ-035 Amount 0 in any mode of 10'h2A5 -> 10'h2A5 after exactly 4 cycles; changing in_data mid-SHIFT leaves the result unchanged.
